// File: rtl/filter_pkg.sv
// Shared types for the filter sequencer: FSM states and the Gray-coded A/B
// control codes driven onto the filter during a sweep.
package filter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PH0    = 3'd1,
        PH1    = 3'd2,
        PH2    = 3'd3,
        PH3    = 3'd4,
        SETTLE = 3'd5,
        CHECK  = 3'd6
    } state_t;

    localparam logic [1:0] AB_OFF = 2'b00;
    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b01;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b10;

    function automatic logic is_phase(input state_t s);
        return (s == PH0) || (s == PH1) || (s == PH2) || (s == PH3);
    endfunction

    // SETTLE keeps the PH3 code so the filter sees no control edge before sampling
    function automatic logic [1:0] ab_code(input state_t s);
        logic [1:0] c;
        c = AB_OFF;
        case (s)
            PH0:     c = AB_PH0;
            PH1:     c = AB_PH1;
            PH2:     c = AB_PH2;
            PH3:     c = AB_PH3;
            SETTLE:  c = AB_PH3;
            default: c = AB_OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; expire is high during the last cycle of a phase that
// was loaded PHASE_LEN cycles earlier.
module phase_timer #(
    parameter int PHASE_LEN = 4,
    parameter int W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= W'(PHASE_LEN);
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/filter_sequencer.sv
// Sweeps a filter's A/B controls through a Gray-coded sequence, counts X-low
// cycles while the controls are active, then samples the filter result.
module filter_sequencer
    import filter_pkg::*;
#(
    parameter int PHASE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic             X,
    input  logic             FilterOut,
    output logic             A,
    output logic             B,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [CNT_W-1:0] ErrCount
);

    state_t state, state_n;
    logic   expire;
    logic   load;
    logic   err_inc;

    phase_timer #(
        .PHASE_LEN (PHASE_LEN),
        .W         (8)
    ) u_timer (
        .clk    (Clk),
        .rst    (Rst),
        .load   (load),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (Start)       state_n = PH0;
            PH0:     if (Abort)       state_n = IDLE;
                     else if (expire) state_n = PH1;
            PH1:     if (Abort)       state_n = IDLE;
                     else if (expire) state_n = PH2;
            PH2:     if (Abort)       state_n = IDLE;
                     else if (expire) state_n = PH3;
            PH3:     if (Abort)       state_n = IDLE;
                     else if (expire) state_n = SETTLE;
            SETTLE:  state_n = Abort ? IDLE : CHECK;
            CHECK:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Reload on every phase entry so each PHx is timed independently
    assign load    = is_phase(state_n) && (state_n != state);
    // An aborting cycle does not count: the count freezes at its pre-abort value
    assign err_inc = is_phase(state) && !Abort && !X && (ErrCount != '1);

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            A        <= 1'b0;
            B        <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
            ErrCount <= '0;
        end else begin
            state    <= state_n;
            {A, B}   <= ab_code(state_n);
            Busy     <= is_phase(state_n) || (state_n == SETTLE);
            Done     <= (state_n == CHECK);
            if (state == SETTLE && state_n == CHECK)
                Pass <= FilterOut;
            if (state == IDLE && Start)
                ErrCount <= '0;
            else if (err_inc)
                ErrCount <= ErrCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench: two sequencer instances (PHASE_LEN=4/CNT_W=8 and PHASE_LEN=1/CNT_W=2)
// share stimulus and are compared every cycle against a sweep-position model.
module tb_filter_sequencer;

    logic Clk, Rst, Start, Abort, X, FilterOut;
    logic a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic a1, b1, busy1, done1, pass1;
    logic [1:0] err1;

    filter_sequencer #(.PHASE_LEN(4), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .X(X),
        .FilterOut(FilterOut), .A(a0), .B(b0), .Busy(busy0), .Done(done0),
        .Pass(pass0), .ErrCount(err0)
    );

    filter_sequencer #(.PHASE_LEN(1), .CNT_W(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .X(X),
        .FilterOut(FilterOut), .A(a1), .B(b1), .Busy(busy1), .Done(done1),
        .Pass(pass1), .ErrCount(err1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Model: a sweep is a position 1..4P+1 (4P control cycles, then SETTLE)
    int plen [2] = '{4, 1};
    int emax [2] = '{255, 3};
    bit m_in [2];
    int m_pos [2];
    int m_err [2];
    bit m_pass [2];
    bit m_done [2];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_ab(input int i);
        int ph;
        if (!m_in[i]) return 0;
        if (m_pos[i] > 4 * plen[i]) return 2;
        ph = (m_pos[i] - 1) / plen[i];
        case (ph)
            0: return 0;
            1: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge Clk);
            for (int i = 0; i < 2; i++) begin
                bit was_done;
                if (Rst) begin
                    m_in[i] = 0; m_pos[i] = 0; m_err[i] = 0;
                    m_pass[i] = 0; m_done[i] = 0;
                end else begin
                    was_done = m_done[i];
                    m_done[i] = 0;
                    if (!m_in[i]) begin
                        if (Start && !was_done) begin
                            m_in[i] = 1; m_pos[i] = 1; m_err[i] = 0;
                        end
                    end else if (Abort) begin
                        m_in[i] = 0;
                    end else begin
                        if (m_pos[i] <= 4 * plen[i] && !X && m_err[i] < emax[i])
                            m_err[i]++;
                        if (m_pos[i] == 4 * plen[i] + 1) begin
                            m_pass[i] = FilterOut; m_done[i] = 1; m_in[i] = 0;
                        end else begin
                            m_pos[i]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                chk("ab0",   int'({a0, b0}), exp_ab(0));
                chk("busy0", int'(busy0),    int'(m_in[0]));
                chk("done0", int'(done0),    int'(m_done[0]));
                chk("pass0", int'(pass0),    int'(m_pass[0]));
                chk("err0",  int'(err0),     m_err[0]);
                chk("ab1",   int'({a1, b1}), exp_ab(1));
                chk("busy1", int'(busy1),    int'(m_in[1]));
                chk("done1", int'(done1),    int'(m_done[1]));
                chk("pass1", int'(pass1),    int'(m_pass[1]));
                chk("err1",  int'(err1),     m_err[1]);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int dn;

    initial begin
        Rst = 1; Start = 0; Abort = 0; X = 1; FilterOut = 1;
        repeat (3) tick();
        chk_en = 1;
        chk("rst_ab", int'({a0, b0}), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_err", int'(err0), 0);
        Rst = 0;
        tick();

        // Nominal sweep: clean X, passing filter
        Start = 1; dn = 0;
        for (int t = 1; t <= 22; t++) begin
            tick();
            Start = 0;
            if (done0) dn++;
            if (t == 1)  begin chk("s1_ab1", int'({a0, b0}), 0); chk("s1_busy1", int'(busy0), 1); end
            if (t == 5)  chk("s1_ab5",  int'({a0, b0}), 1);
            if (t == 9)  chk("s1_ab9",  int'({a0, b0}), 3);
            if (t == 13) chk("s1_ab13", int'({a0, b0}), 2);
            if (t == 17) chk("s1_done17", int'(done0), 0);
            if (t == 18) begin chk("s1_done18", int'(done0), 1); chk("s1_busy18", int'(busy0), 0); end
        end
        chk("s1_dn", dn, 1);
        chk("s1_pass", int'(pass0), 1);
        chk("s1_err", int'(err0), 0);

        // X low for cycles 6-8, filter fails at SETTLE
        Start = 1; dn = 0;
        for (int t = 1; t <= 22; t++) begin
            tick();
            Start = 0;
            X = (t >= 6 && t <= 8) ? 1'b0 : 1'b1;
            FilterOut = (t == 17) ? 1'b0 : 1'b1;
            if (done0) dn++;
        end
        X = 1; FilterOut = 1;
        chk("s2_err", int'(err0), 3);
        chk("s2_pass", int'(pass0), 0);
        chk("s2_dn", dn, 1);

        // X low throughout: narrow counter saturates
        Start = 1; X = 0;
        for (int t = 1; t <= 22; t++) begin
            tick();
            Start = 0;
        end
        X = 1;
        chk("s3_err_wide", int'(err0), 16);
        chk("s3_err_sat", int'(err1), 3);

        // Abort at cycle 10 with two earlier X-low cycles
        Start = 1; dn = 0;
        for (int t = 1; t <= 22; t++) begin
            tick();
            Start = 0;
            X = (t == 2 || t == 3) ? 1'b0 : 1'b1;
            Abort = (t == 10);
            if (done0) dn++;
            if (t == 11) begin
                chk("s4_busy", int'(busy0), 0);
                chk("s4_ab", int'({a0, b0}), 0);
                chk("s4_err", int'(err0), 2);
            end
        end
        chk("s4_dn", dn, 0);
        chk("s4_err_hold", int'(err0), 2);

        // Re-pulsed Start at 5 and 18 ignored, 19 accepted
        Start = 1; dn = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            Start = (t == 5 || t == 18 || t == 19);
            X = (t == 2) ? 1'b0 : 1'b1;
            if (done0) dn++;
            if (t == 18) chk("s5_dn18", dn, 1);
            if (t == 19) chk("s5_err19", int'(err0), 1);
            if (t == 20) begin chk("s5_err20", int'(err0), 0); chk("s5_busy20", int'(busy0), 1); end
        end
        chk("s5_dn", dn, 2);

        // Start and Abort together in IDLE: Start wins
        Start = 1; Abort = 1;
        tick();
        Start = 0; Abort = 0;
        chk("s6_busy", int'(busy0), 1);
        repeat (20) tick();

        // Reset mid-sweep
        Start = 1; dn = 0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            Start = 0;
            X = (t == 3) ? 1'b0 : 1'b1;
            Rst = (t == 7);
            if (t >= 8 && done0) dn++;
            if (t == 8) begin
                chk("s7_ab", int'({a0, b0}), 0);
                chk("s7_busy", int'(busy0), 0);
                chk("s7_pass", int'(pass0), 0);
                chk("s7_err", int'(err0), 0);
            end
        end
        chk("s7_dn", dn, 0);

        // Random traffic, checked by the model every cycle
        for (int n = 0; n < 1500; n++) begin
            Start     = ($urandom % 6) == 0;
            Abort     = ($urandom % 40) == 0;
            Rst       = ($urandom % 200) == 0;
            X         = ($urandom % 4) != 0;
            FilterOut = $urandom % 2;
            tick();
        end
        Rst = 0; Start = 0; Abort = 0;
        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
